round_robin_arbiter4: RTL and testbench

ROUND_ROBIN_ARBITER4 -- requirements
Module: round_robin_arbiter4

---
 rtl/round_robin_arbiter4_pkg.sv | 18 +
 rtl/round_robin_arbiter4_onehot_to_index4.sv | 17 +
 rtl/round_robin_arbiter4.sv | 110 +++++++++++
 tb/tb_round_robin_arbiter4.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/round_robin_arbiter4_pkg.sv
// Shared definitions for the 4-requester round-robin arbiter:
// FSM state encoding, requester count, index width and a one-hot helper.
package round_robin_arbiter4_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Build the one-hot grant vector for a requester index.
  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/round_robin_arbiter4_onehot_to_index4.sv
// onehot_to_index4: combinational encoder from the one-hot grant vector to
// its binary index. An all-zero input encodes to 2'b00.
module onehot_to_index4
  import round_robin_arbiter4_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_onehot,
  output logic [IDX_W-1:0]   o_idx
);

  // Each index bit is the OR of the one-hot bits whose index has that bit set.
  always_comb begin
    o_idx    = '0;
    o_idx[1] = i_onehot[3] | i_onehot[2];
    o_idx[0] = i_onehot[3] | i_onehot[1];
  end

endmodule

// File: rtl/round_robin_arbiter4.sv
// round_robin_arbiter4: 4-requester round-robin arbiter with a two-state
// IDLE/GRANT FSM and registered one-hot grant. A holder keeps the grant
// while its request stays high; release inserts one idle bubble before the
// next arbitration. Define RR_ARB_TIMEOUT_EN to compile in a hold counter
// that revokes the grant after MAX_HOLD consecutive grant cycles.
module round_robin_arbiter4
  import round_robin_arbiter4_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("MAX_HOLD must be in the range 2..255");
  end

  state_t             r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic               r_grant_valid;
  logic [IDX_W-1:0]   r_ptr;

  logic [IDX_W-1:0]   w_grant_idx;
  logic [IDX_W-1:0]   w_cand;
  logic [IDX_W-1:0]   w_win;
  logic               w_found;

`ifdef RR_ARB_TIMEOUT_EN
  localparam int HOLD_W = 8;
  logic [HOLD_W-1:0]  r_hold;
`endif

  // Priority scan: first set request starting at r_ptr, wrapping mod 4.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = r_ptr + IDX_W'(k);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  onehot_to_index4 u_enc (
    .i_onehot (r_grant),
    .o_idx    (w_grant_idx)
  );

  // Arbitration FSM: grant a winner from IDLE, hold until release (or timeout).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_ptr         <= '0;
`ifdef RR_ARB_TIMEOUT_EN
      r_hold        <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state       <= GRANT;
            r_grant       <= idx_to_onehot(w_win);
            r_grant_valid <= 1'b1;
            r_ptr         <= w_win + IDX_W'(1);
`ifdef RR_ARB_TIMEOUT_EN
            r_hold        <= '0;
`endif
          end
        end
        GRANT: begin
          if (!req[w_grant_idx]) begin
            r_state       <= IDLE;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
          end
`ifdef RR_ARB_TIMEOUT_EN
          // Holder still requesting: revoke once it has had MAX_HOLD cycles.
          else if (r_hold == HOLD_W'(MAX_HOLD - 1)) begin
            r_state       <= IDLE;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
          end else begin
            r_hold        <= r_hold + HOLD_W'(1);
          end
`endif
        end
        default: begin
          r_state       <= IDLE;
          r_grant       <= '0;
          r_grant_valid <= 1'b0;
        end
      endcase
    end
  end

  assign grant       = r_grant;
  assign grant_idx   = w_grant_idx;
  assign grant_valid = r_grant_valid;

endmodule

// File: tb/tb_round_robin_arbiter4.sv
// Scoreboard bench for round_robin_arbiter4: stimulus pushes the grant
// expected after each sampled request; a monitor pops and compares it
// one time unit after every rising edge, and also checks the output
// invariants every cycle. Define RR_ARB_TIMEOUT_EN to run the timeout case.
module tb_round_robin_arbiter4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_valid;

  int checks   = 0;
  int failures = 0;

  logic [3:0] exp_q[$];

  round_robin_arbiter4 #(.MAX_HOLD(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] enc(input logic [3:0] g);
    case (g)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive req at the falling edge; the grant after the next rising edge is exp.
  task automatic step(input logic [3:0] r, input logic [3:0] exp);
    @(negedge clk);
    req = r;
    exp_q.push_back(exp);
  endtask

  // Asynchronous reset pulse: outputs must clear with no clock edge.
  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst_grant", grant, 0);
    check("async_rst_idx", grant_idx, 0);
    check("async_rst_valid", grant_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compare against the scoreboard and check invariants each cycle.
  always @(posedge clk) begin
    logic [3:0] e;
    #1;
    check("onehot", ($countones(grant) <= 1) ? 1 : 0, 1);
    check("idx_encode", grant_idx, enc(grant));
    check("valid_nonzero", grant_valid, (grant != 4'b0) ? 1 : 0);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("grant", grant, e);
    end
  end

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    #2;
    check("reset_grant", grant, 0);
    check("reset_valid", grant_valid, 0);
    check("reset_idx", grant_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic grant, release bubble, then requester 2 from ptr=1.
    step(4'b0101, 4'b0001);
    step(4'b0100, 4'b0000);
    step(4'b0100, 4'b0100);
    step(4'b0000, 4'b0000);

    // All requesting, each holder drops for one cycle after 3 grant cycles.
    pulse_reset();
    for (int h = 0; h < 4; h++) begin
      for (int c = 0; c < 3; c++) step(4'b1111, 4'b0001 << h);
      step(4'b1111 & ~(4'b0001 << h), 4'b0000);
    end
    step(4'b1111, 4'b0001);
    step(4'b0000, 4'b0000);

    // Holder 3 not preempted, then ptr wraps to requester 0.
    pulse_reset();
    step(4'b1000, 4'b1000);
    step(4'b1001, 4'b1000);
    step(4'b0001, 4'b0000);
    step(4'b0001, 4'b0001);
    step(4'b0000, 4'b0000);

    // Reset mid-grant, then arbitration restarts with ptr=0.
    pulse_reset();
    step(4'b0100, 4'b0100);
    step(4'b0100, 4'b0100);
    @(negedge clk);
    req   = 4'b0110;
    rst_n = 1'b0;
    #1;
    check("midgrant_rst_grant", grant, 0);
    check("midgrant_rst_idx", grant_idx, 0);
    check("midgrant_rst_valid", grant_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(4'b0010);
    step(4'b0000, 4'b0000);
    step(4'b0000, 4'b0000);

    pulse_reset();
`ifdef RR_ARB_TIMEOUT_EN
    // Forced revoke after 4 cycles, alternating between the two requesters.
    for (int c = 0; c < 4; c++) step(4'b0011, 4'b0001);
    step(4'b0011, 4'b0000);
    for (int c = 0; c < 4; c++) step(4'b0011, 4'b0010);
    step(4'b0011, 4'b0000);
    step(4'b0011, 4'b0001);
    step(4'b0000, 4'b0000);
`else
    // No timeout: holder 0 keeps the grant indefinitely.
    for (int c = 0; c < 50; c++) step(4'b0011, 4'b0001);
    step(4'b0000, 4'b0000);
`endif

    step(4'b0000, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
